// File: rtl/sum_accum_pkg.sv
// Shared types and limit helpers for the windowed saturating accumulator.
package sum_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Signed range limits for a w-bit accumulator, as 64-bit patterns (w <= 64).
    function automatic logic [63:0] acc_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] acc_min(input int w);
        return ~64'd0 << (w - 1);
    endfunction

endpackage

// File: rtl/sum_accum_sat_add.sv
// Combinational saturating add: ACC_W-bit signed accumulator plus WIDTH-bit signed sample.
import sum_accum_pkg::*;

module sat_add #(
    parameter int ACC_W = 40,
    parameter int WIDTH = 32
) (
    input  logic [ACC_W-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);
    localparam logic [ACC_W-1:0] MAX = ACC_W'(acc_max(ACC_W));
    localparam logic [ACC_W-1:0] MIN = ACC_W'(acc_min(ACC_W));

    logic [ACC_W:0] ext;

    assign ext = {a[ACC_W-1], a} + {{(ACC_W + 1 - WIDTH){b[WIDTH-1]}}, b};
    assign ovf = ext[ACC_W] ^ ext[ACC_W-1];

    // On overflow both operands share a sign, which the extra top bit still carries.
    always_comb begin
        sum = ext[ACC_W-1:0];
        if (ovf) sum = ext[ACC_W] ? MIN : MAX;
    end

endmodule

// File: rtl/sum_accum.sv
// Accumulates len valid samples into a saturating signed total, pulsing out_valid once per window.
import sum_accum_pkg::*;

module sum_accum #(
    parameter int WIDTH = 32,
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             busy,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_sat
);
    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic             sat;
    logic [ACC_W-1:0] acc_nxt;
    logic             ovf;

    sat_add #(.ACC_W(ACC_W), .WIDTH(WIDTH)) u_add (
        .a   (acc),
        .b   (in_data),
        .sum (acc_nxt),
        .ovf (ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            sat       <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= '0;
                        sat  <= 1'b0;
                        cnt  <= len;
                        busy <= 1'b1;
                        if (len != '0) begin
                            state <= ACCUM;
                        end else begin
                            // Empty window still reports, with a zero total.
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_sum   <= '0;
                            out_sat   <= 1'b0;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc <= acc_nxt;
                        sat <= sat | ovf;
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_sum   <= acc_nxt;
                            out_sat   <= sat | ovf;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accum.sv
// Directed bench: two instances (ACC_W=40 and ACC_W=34) share one stimulus stream.
module tb_sum_accum;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [31:0] in_data;

    logic        busy_a, valid_a, sat_a;
    logic [39:0] sum_a;
    logic        busy_b, valid_b, sat_b;
    logic [33:0] sum_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sum_accum #(.WIDTH(32), .ACC_W(40), .LEN_W(8)) u40 (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data),
        .busy(busy_a), .out_valid(valid_a), .out_sum(sum_a), .out_sat(sat_a)
    );

    sum_accum #(.WIDTH(32), .ACC_W(34), .LEN_W(8)) u34 (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data),
        .busy(busy_b), .out_valid(valid_b), .out_sum(sum_b), .out_sat(sat_b)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
        step();
        chk("rst_busy",  busy_a, 1'b0);
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_sum",   $signed(sum_a), 0);
        chk("rst_sat",   sat_b, 1'b0);
        reset = 1'b0;
        step();

        // 1: len=4, samples with gaps
        go(8'd4);
        chk("t1_busy_after_start", busy_a, 1'b1);
        feed(32'd10);
        step();
        feed(-32'sd3);
        step();
        step();
        feed(32'd7);
        chk("t1_no_early_valid", valid_a, 1'b0);
        feed(32'd1);
        chk("t1_valid", valid_a, 1'b1);
        chk("t1_sum",   $signed(sum_a), 15);
        chk("t1_sat",   sat_a, 1'b0);
        chk("t1_busy_done", busy_a, 1'b1);
        step();
        chk("t1_valid_pulse", valid_a, 1'b0);
        chk("t1_busy_idle",   busy_a, 1'b0);
        chk("t1_sum_held",    $signed(sum_a), 15);

        // 2: positive saturation on 34-bit instance
        go(8'd5);
        for (int i = 0; i < 5; i++) feed(32'h7FFF_FFFF);
        chk("t2_valid34", valid_b, 1'b1);
        chk("t2_sum34",   $signed(sum_b), 64'sd8589934591);
        chk("t2_sat34",   sat_b, 1'b1);
        chk("t2_sum40",   $signed(sum_a), 64'sd10737418235);
        chk("t2_sat40",   sat_a, 1'b0);
        step();
        go(8'd4);
        for (int i = 0; i < 4; i++) feed(32'h7FFF_FFFF);
        chk("t2b_sum34", $signed(sum_b), 64'sd8589934588);
        chk("t2b_sat34", sat_b, 1'b0);
        step();

        // 3: negative saturation and exact boundary
        go(8'd5);
        for (int i = 0; i < 5; i++) feed(32'h8000_0000);
        chk("t3_sum34", $signed(sum_b), -64'sd8589934592);
        chk("t3_sat34", sat_b, 1'b1);
        step();
        go(8'd4);
        for (int i = 0; i < 4; i++) feed(32'h8000_0000);
        chk("t3b_sum34", $signed(sum_b), -64'sd8589934592);
        chk("t3b_sat34", sat_b, 1'b0);
        step();

        // 4: empty window, ignored in_valid in IDLE/DONE, ignored start in ACCUM
        feed(32'd99);
        chk("t4_idle_drop_valid", valid_a, 1'b0);
        chk("t4_idle_drop_busy",  busy_a, 1'b0);
        go(8'd0);
        chk("t4_empty_valid", valid_a, 1'b1);
        chk("t4_empty_sum",   $signed(sum_a), 0);
        feed(32'd55);
        chk("t4_done_pulse", valid_a, 1'b0);
        chk("t4_done_sum",   $signed(sum_a), 0);
        chk("t4_done_busy",  busy_a, 1'b0);
        go(8'd2);
        start = 1'b1; len = 8'd7;
        feed(32'd4);
        start = 1'b0;
        feed(32'd6);
        chk("t4_restart_ign_valid", valid_a, 1'b1);
        chk("t4_restart_ign_sum",   $signed(sum_a), 10);
        step();

        // 5: asynchronous reset mid-window
        go(8'd3);
        feed(32'd8);
        feed(32'd9);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_busy",  busy_a, 1'b0);
        chk("t5_async_sum",   $signed(sum_a), 0);
        chk("t5_async_valid", valid_a, 1'b0);
        step();
        reset = 1'b0;
        feed(32'd1);
        chk("t5_no_valid_after", valid_a, 1'b0);
        go(8'd1);
        feed(-32'sd5);
        chk("t5_new_valid", valid_a, 1'b1);
        chk("t5_new_sum",   $signed(sum_a), -5);
        step();

        // 6: back-to-back windows
        go(8'd2);
        feed(32'd1);
        feed(32'd2);
        chk("t6_w1_sum", $signed(sum_a), 3);
        step();
        go(8'd2);
        chk("t6_held", $signed(sum_a), 3);
        feed(32'd100);
        feed(32'd200);
        chk("t6_w2_valid", valid_a, 1'b1);
        chk("t6_w2_sum",   $signed(sum_a), 300);
        chk("t6_w2_sat",   sat_a, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
